// File: rtl/usb_tx_wire_arbiter_pkg.sv
// Shared serial-interface-engine constants: connect states, arbiter state codes,
// requester indices and the per-requester wire payload.
package usb_tx_wire_arbiter_pkg;

  localparam logic [1:0] DISCONNECT         = 2'b00;
  localparam logic [1:0] LOW_SPEED_CONNECT  = 2'b01;
  localparam logic [1:0] FULL_SPEED_CONNECT = 2'b10;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned REQ_SOF = 0;
  localparam int unsigned REQ_HC  = 1;
  localparam int unsigned REQ_SIG = 2;
  localparam int unsigned CNT_W   = 4;

  localparam logic [NUM_REQ-1:0] GNT_SOF = NUM_REQ'(1) << REQ_SOF;
  localparam logic [NUM_REQ-1:0] GNT_HC  = NUM_REQ'(1) << REQ_HC;
  localparam logic [NUM_REQ-1:0] GNT_SIG = NUM_REQ'(1) << REQ_SIG;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_GRANTED    = 2'd1,
    ARB_TURNAROUND = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [1:0] data;
    logic       ctrl;
    logic       wen;
  } tx_wire_t;

  localparam tx_wire_t TX_WIRE_IDLE = '0;

endpackage

// File: rtl/tx_wire_mux.sv
// One-hot 3:1 selector of requester wire payloads; idle values when nothing is granted.
module tx_wire_mux
  import usb_tx_wire_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] gnt,
  input  tx_wire_t           sof,
  input  tx_wire_t           hc,
  input  tx_wire_t           sig,
  output tx_wire_t           tx_c
);

  always_comb begin
    tx_c = TX_WIRE_IDLE;
    case (gnt)
      GNT_SOF: tx_c = sof;
      GNT_HC:  tx_c = hc;
      GNT_SIG: tx_c = sig;
      default: tx_c = TX_WIRE_IDLE;
    endcase
  end

endmodule

// File: rtl/usb_tx_wire_arbiter.sv
// Arbitrates the shared USB transmit wire between SOF, host-control and signalling
// requesters, with a forced idle turnaround between successive owners.
module usb_tx_wire_arbiter
  import usb_tx_wire_arbiter_pkg::*;
#(
  parameter int unsigned TURNAROUND_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sofReq,
  input  logic       hcReq,
  input  logic       sigReq,
  output logic       sofGnt,
  output logic       hcGnt,
  output logic       sigGnt,
  input  logic [1:0] sofWireData,
  input  logic [1:0] hcWireData,
  input  logic [1:0] sigWireData,
  input  logic       sofWireCtrl,
  input  logic       hcWireCtrl,
  input  logic       sigWireCtrl,
  input  logic       sofWireWEn,
  input  logic       hcWireWEn,
  input  logic       sigWireWEn,
  output logic [1:0] TxWireDataOut,
  output logic       TxWireCtrlOut,
  output logic       TxWireDataWEn,
  output logic       rxInhibitOut
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURNAROUND_CYCLES - 1);

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] req, gnt, gnt_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last_hc, last_hc_nxt;
  tx_wire_t           sof_w, hc_w, sig_w, mux_c, tx_q;
  logic               rx_inhibit;

  assign req[REQ_SOF] = sofReq;
  assign req[REQ_HC]  = hcReq;
  assign req[REQ_SIG] = sigReq;

  assign sof_w = {sofWireData, sofWireCtrl, sofWireWEn};
  assign hc_w  = {hcWireData, hcWireCtrl, hcWireWEn};
  assign sig_w = {sigWireData, sigWireCtrl, sigWireWEn};

  tx_wire_mux u_tx_wire_mux (
    .gnt  (gnt),
    .sof  (sof_w),
    .hc   (hc_w),
    .sig  (sig_w),
    .tx_c (mux_c)
  );

  // Next-state: signalling wins outright, SOF/HC alternate on the last-winner pointer.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    cnt_nxt     = cnt;
    last_hc_nxt = last_hc;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          state_nxt = ARB_GRANTED;
          if (sigReq) begin
            gnt_nxt = GNT_SIG;
          end else if (sofReq && (!hcReq || last_hc)) begin
            gnt_nxt     = GNT_SOF;
            last_hc_nxt = 1'b0;
          end else begin
            gnt_nxt     = GNT_HC;
            last_hc_nxt = 1'b1;
          end
        end
      end
      ARB_GRANTED: begin
        if ((gnt & req) == '0) begin
          gnt_nxt   = '0;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ARB_TURNAROUND;
        end
      end
      ARB_TURNAROUND: begin
        if (cnt == '0) begin
          state_nxt = ARB_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Wire outputs only carry the owner's payload while it keeps the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      gnt        <= '0;
      cnt        <= '0;
      last_hc    <= 1'b1;
      tx_q       <= TX_WIRE_IDLE;
      rx_inhibit <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      cnt        <= cnt_nxt;
      last_hc    <= last_hc_nxt;
      tx_q       <= (state_nxt == ARB_GRANTED) ? mux_c : TX_WIRE_IDLE;
      rx_inhibit <= (state_nxt != ARB_IDLE);
    end
  end

  assign sofGnt        = gnt[REQ_SOF];
  assign hcGnt         = gnt[REQ_HC];
  assign sigGnt        = gnt[REQ_SIG];
  assign TxWireDataOut = tx_q.data;
  assign TxWireCtrlOut = tx_q.ctrl;
  assign TxWireDataWEn = tx_q.wen;
  assign rxInhibitOut  = rx_inhibit;

endmodule
